// File: rtl/noc_flit_serializer_if.sv
// rtl/noc_flit_serializer_if.sv - flit-in / phit-out handshake bundle for the NoC serializer
interface noc_flit_serializer_if #(
  parameter int FLIT_W = 64,
  parameter int PHIT_W = 4,
  parameter int VC_W   = 2,
  parameter int LVL_W  = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [FLIT_W-1:0] in_data;
  logic [VC_W-1:0]   in_vc;
  logic              out_valid;
  logic              out_ready;
  logic [PHIT_W-1:0] out_data;
  logic [VC_W-1:0]   out_vc;
  logic              out_sof;
  logic              out_eof;
  logic [LVL_W-1:0]  fifo_level;

  modport master (
    output in_valid, in_data, in_vc, out_ready,
    input  in_ready, out_valid, out_data, out_vc, out_sof, out_eof, fifo_level
  );

  modport slave (
    input  in_valid, in_data, in_vc, out_ready,
    output in_ready, out_valid, out_data, out_vc, out_sof, out_eof, fifo_level
  );
endinterface

// File: rtl/noc_flit_serializer.sv
// rtl/noc_flit_serializer.sv - flit FIFO that streams its head flit LSB-first as VC-tagged phits
module noc_flit_serializer #(
  parameter int FLIT_W = 64,
  parameter int PHIT_W = 4,
  parameter int DEPTH  = 2,
  parameter int VC_W   = 2
) (
  input  logic clk,
  input  logic rst,
  noc_flit_serializer_if.slave bus
);
  localparam int NPHIT = FLIT_W / PHIT_W;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IDX_W = (NPHIT > 1) ? $clog2(NPHIT) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int ENT_W = VC_W + FLIT_W;

  if ((FLIT_W % PHIT_W) != 0 || NPHIT < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
    $error("noc_flit_serializer: bad FLIT_W/PHIT_W/DEPTH combination");
  end

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0] phit_idx_q, phit_idx_d;
  logic [LVL_W-1:0] level_q, level_d;

  logic                          in_ready;
  logic                          out_valid;
  logic                          push;
  logic                          xfer;
  logic                          pop;
  logic                          last_phit;
  logic [ENT_W-1:0]              head;
  logic [NPHIT-1:0][PHIT_W-1:0]  head_phits;

  // The head entry is read in place; the phit index selects the slice on the link.
  assign head       = mem_q[rd_ptr_q];
  assign head_phits = head[FLIT_W-1:0];
  assign in_ready   = level_q < LVL_W'(DEPTH);
  assign out_valid  = level_q != '0;
  assign last_phit  = phit_idx_q == IDX_W'(NPHIT - 1);
  assign push       = bus.in_valid & in_ready;
  assign xfer       = out_valid & bus.out_ready;
  assign pop        = xfer & last_phit;

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_valid ? head_phits[phit_idx_q] : '0;
  assign bus.out_vc     = out_valid ? head[ENT_W-1:FLIT_W] : '0;
  assign bus.out_sof    = out_valid & (phit_idx_q == '0);
  assign bus.out_eof    = out_valid & last_phit;
  assign bus.fifo_level = level_q;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    phit_idx_d = phit_idx_q;
    level_d    = level_q;

    if (push) begin
      mem_d[wr_ptr_q] = {bus.in_vc, bus.in_data};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    if (xfer) begin
      if (last_phit) begin
        phit_idx_d = '0;
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      end else begin
        phit_idx_d = phit_idx_q + IDX_W'(1);
      end
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      phit_idx_q <= '0;
      level_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      phit_idx_q <= phit_idx_d;
      level_q    <= level_d;
    end
  end

  // Payload storage needs no reset: level gates every read of it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_noc_flit_serializer.sv
// tb/tb_noc_flit_serializer.sv - scoreboard bench for noc_flit_serializer (default and 32/8/4 configs)
module tb_noc_flit_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  noc_flit_serializer_if #(.FLIT_W(64), .PHIT_W(4), .VC_W(2), .LVL_W(2)) if0 ();
  noc_flit_serializer_if #(.FLIT_W(32), .PHIT_W(8), .VC_W(2), .LVL_W(3)) if1 ();

  noc_flit_serializer #(.FLIT_W(64), .PHIT_W(4), .DEPTH(2), .VC_W(2)) u0 (
    .clk(clk), .rst(rst), .bus(if0)
  );
  noc_flit_serializer #(.FLIT_W(32), .PHIT_W(8), .DEPTH(4), .VC_W(2)) u1 (
    .clk(clk), .rst(rst), .bus(if1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int nphits1  = 0;
  bit rand_rdy0 = 1'b0;
  bit rand_rdy1 = 1'b0;
  logic [63:0] exp0 [$];
  logic [63:0] exp1 [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_rdy0) if0.out_ready = 1'($urandom_range(0, 1));
      if (rand_rdy1) if1.out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Reference: a flit becomes NPHIT phits, LSB first, sof on the first, eof on the last.
  task automatic push0(input logic [63:0] d, input logic [1:0] vc, output int waits);
    waits = 0;
    if0.in_valid = 1'b1;
    if0.in_data  = d;
    if0.in_vc    = vc;
    @(negedge clk);
    while (!if0.in_ready && waits <= 300) begin
      waits++;
      step(1);
      @(negedge clk);
    end
    if (!if0.in_ready) begin
      n_checks++;
      $display("FAIL push0_timeout: in_ready stayed 0, required 1 within 300 cycles");
    end else begin
      for (int i = 0; i < 16; i++)
        exp0.push_back({i == 0, i == 15, vc, 4'(d >> (4 * i))});
    end
    step(1);
    if0.in_valid = 1'b0;
  endtask

  task automatic push1(input logic [31:0] d, input logic [1:0] vc);
    int waits = 0;
    if1.in_valid = 1'b1;
    if1.in_data  = d;
    if1.in_vc    = vc;
    @(negedge clk);
    while (!if1.in_ready && waits <= 300) begin
      waits++;
      step(1);
      @(negedge clk);
    end
    if (!if1.in_ready) begin
      n_checks++;
      $display("FAIL push1_timeout: in_ready stayed 0, required 1 within 300 cycles");
    end else begin
      for (int i = 0; i < 4; i++)
        exp1.push_back({i == 0, i == 3, vc, 8'(d >> (8 * i))});
    end
    step(1);
    if1.in_valid = 1'b0;
  endtask

  task automatic drain0();
    int k = 0;
    while (if0.out_valid && k < 300) begin
      step(1);
      k++;
    end
    chk("drain0_idle", {if0.out_valid, if0.fifo_level}, 3'b000);
  endtask

  task automatic drain1();
    int k = 0;
    while (if1.out_valid && k < 600) begin
      step(1);
      k++;
    end
    chk("drain1_idle", {if1.out_valid, if1.fifo_level}, 4'b0000);
  endtask

  always @(negedge clk) begin
    if (!rst && if0.out_valid && if0.out_ready) begin
      if (exp0.size() == 0) begin
        n_checks++;
        $display("FAIL phit0_unexpected: got phit %h, required no phit", if0.out_data);
      end else begin
        chk("phit0", {if0.out_sof, if0.out_eof, if0.out_vc, if0.out_data}, exp0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && if1.out_valid && if1.out_ready) begin
      nphits1++;
      if (exp1.size() == 0) begin
        n_checks++;
        $display("FAIL phit1_unexpected: got phit %h, required no phit", if1.out_data);
      end else begin
        chk("phit1", {if1.out_sof, if1.out_eof, if1.out_vc, if1.out_data}, exp1.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int w;
    logic [63:0] a;
    if0.in_valid = 1'b0; if0.in_data = '0; if0.in_vc = '0; if0.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.in_data = '0; if1.in_vc = '0; if1.out_ready = 1'b1;
    #1;
    chk("reset0_state", {if0.in_ready, if0.out_valid, if0.out_sof, if0.out_eof, if0.out_data, if0.out_vc, if0.fifo_level},
        {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 2'd0});
    chk("reset1_state", {if1.in_ready, if1.out_valid, if1.out_data, if1.fifo_level}, {1'b1, 1'b0, 8'h00, 3'd0});
    step(2);
    rst = 1'b0;
    step(1);

    // single flit, continuous ready
    push0(64'hFEDCBA9876543210, 2'd2, w);
    chk("t1_first_phit", {if0.out_valid, if0.out_sof, if0.out_eof, if0.out_vc, if0.out_data, if0.fifo_level},
        {1'b1, 1'b1, 1'b0, 2'd2, 4'h0, 2'd1});
    step(15);
    chk("t1_last_phit", {if0.out_sof, if0.out_eof, if0.out_data}, {1'b0, 1'b1, 4'hF});
    step(1);
    chk("t1_idle", {if0.out_valid, if0.fifo_level}, 3'b000);

    // back-pressure after phit 3
    push0(64'hFEDCBA9876543210, 2'd1, w);
    step(3);
    chk("t2_phit3", if0.out_data, 4'h3);
    if0.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("t2_stall_hold", {if0.out_valid, if0.out_sof, if0.out_eof, if0.out_vc, if0.out_data},
          {1'b1, 1'b0, 1'b0, 2'd1, 4'h3});
    end
    if0.out_ready = 1'b1;
    step(1);
    chk("t2_resume_phit4", if0.out_data, 4'h4);
    drain0();

    // full FIFO: third offer waits until A's eof has transferred
    push0({$urandom(), $urandom()}, 2'd0, w);
    push0({$urandom(), $urandom()}, 2'd1, w);
    chk("t3_full", {if0.in_ready, if0.fifo_level}, {1'b0, 2'd2});
    push0({$urandom(), $urandom()}, 2'd2, w);
    chk("t3_c_wait_cycles", 64'(w), 64'd15);
    drain0();

    // push on the eof cycle with one flit resident
    push0({$urandom(), $urandom()}, 2'd1, w);
    step(15);
    chk("t4_eof_level1", {if0.out_eof, if0.fifo_level, if0.in_ready}, {1'b1, 2'd1, 1'b1});
    a = {$urandom(), $urandom()};
    push0(a, 2'd3, w);
    chk("t4_b_sof", {if0.out_valid, if0.out_sof, if0.out_vc, if0.out_data, if0.fifo_level},
        {1'b1, 1'b1, 2'd3, a[3:0], 2'd1});
    drain0();

    // asynchronous reset in the middle of a flit
    push0({$urandom(), $urandom()}, 2'd2, w);
    step(7);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_reset", {if0.out_valid, if0.in_ready, if0.fifo_level, if0.out_sof}, {1'b0, 1'b1, 2'd0, 1'b0});
    exp0.delete();
    exp1.delete();
    step(1);
    rst = 1'b0;
    step(1);
    a = {$urandom(), $urandom()};
    push0(a, 2'd0, w);
    chk("t5_restart_sof", {if0.out_sof, if0.out_data}, {1'b1, a[3:0]});
    drain0();

    // randomized traffic on the default configuration
    rand_rdy0 = 1'b1;
    for (int i = 0; i < 20; i++) push0({$urandom(), $urandom()}, 2'($urandom_range(0, 3)), w);
    rand_rdy0 = 1'b0;
    if0.out_ready = 1'b1;
    drain0();

    // 32/8/4 configuration: pointer wrap under random back-pressure
    nphits1 = 0;
    rand_rdy1 = 1'b1;
    for (int i = 0; i < 12; i++) push1($urandom(), 2'($urandom_range(0, 3)));
    rand_rdy1 = 1'b0;
    if1.out_ready = 1'b1;
    drain1();
    chk("t6_phit_count", 64'(nphits1), 64'd48);

    chk("sb0_empty", 64'(exp0.size()), 64'd0);
    chk("sb1_empty", 64'(exp1.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
